// File: rtl/axis_packetizer.sv
// ============================================================================
// Module   : axis_packetizer
// Purpose  : Frames a headerless valid/ready word stream into AXI-Stream
//            packets with TLAST/TID/TUSER/TDEST and a 2-entry registered output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_packetizer #(
    parameter int DATAW = 32,
    parameter int IDW   = 4,
    parameter int USERW = 4,
    parameter int DESTW = 4,
    parameter int LENW  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [DATAW-1:0] IN_DATA,
    input  logic [LENW-1:0]  CFG_LEN,
    input  logic [DESTW-1:0] CFG_DEST,
    input  logic [IDW-1:0]   CFG_ID,
    input  logic [USERW-1:0] CFG_USER,
    input  logic             FLUSH,
    output logic             AXIS_M_TVALID,
    input  logic             AXIS_M_TREADY,
    output logic [DATAW-1:0] AXIS_M_TDATA,
    output logic             AXIS_M_TLAST,
    output logic [IDW-1:0]   AXIS_M_TID,
    output logic [USERW-1:0] AXIS_M_TUSER,
    output logic [DESTW-1:0] AXIS_M_TDEST,
    output logic [15:0]      PKT_CNT
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OPEN = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             last;
        logic [IDW-1:0]   id;
        logic [USERW-1:0] user;
        logic [DESTW-1:0] dest;
    } beat_t;

    state_t           state_q, state_d;
    logic [LENW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [DESTW-1:0] dest_q, dest_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [USERW-1:0] user_q, user_d;
    logic             flush_pend_q, flush_pend_d;

    beat_t            main_q, main_d;
    logic             main_valid_q, main_valid_d;
    beat_t            skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic             accept;
    logic             main_drain;
    logic [LENW-1:0]  eff_len;
    beat_t            new_beat;

    always_comb begin
        accept     = IN_VALID && in_ready_q;
        main_drain = main_valid_q && AXIS_M_TREADY;
        eff_len    = (CFG_LEN == '0) ? LENW'(1) : CFG_LEN;

        // Framing of the word being offered this cycle
        new_beat.data = IN_DATA;
        if (state_q == S_IDLE) begin
            new_beat.id   = CFG_ID;
            new_beat.user = CFG_USER;
            new_beat.dest = CFG_DEST;
            new_beat.last = (eff_len == LENW'(1)) || FLUSH || flush_pend_q;
        end else begin
            new_beat.id   = id_q;
            new_beat.user = user_q;
            new_beat.dest = dest_q;
            new_beat.last = ((beat_cnt_q + LENW'(1)) == len_q) || flush_pend_q || FLUSH;
        end

        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        dest_d       = dest_q;
        id_d         = id_q;
        user_d       = user_q;
        flush_pend_d = flush_pend_q;

        if (accept) begin
            flush_pend_d = 1'b0;
            if (state_q == S_IDLE) begin
                len_d  = eff_len;
                dest_d = CFG_DEST;
                id_d   = CFG_ID;
                user_d = CFG_USER;
            end
            if (new_beat.last) begin
                state_d    = S_IDLE;
                beat_cnt_d = '0;
            end else begin
                state_d    = S_OPEN;
                beat_cnt_d = (state_q == S_IDLE) ? LENW'(1) : beat_cnt_q + LENW'(1);
            end
        end else if (FLUSH) begin
            flush_pend_d = 1'b1;
        end

        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        pkt_cnt_d    = pkt_cnt_q;

        if (main_drain && main_q.last) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end

        // IN_READY mirrors an empty skid, so an accept never coincides with a
        // skid entry waiting to move forward.
        if (!main_valid_q || main_drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_beat;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_beat;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            dest_q       <= '0;
            id_q         <= '0;
            user_q       <= '0;
            flush_pend_q <= 1'b0;
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            dest_q       <= dest_d;
            id_q         <= id_d;
            user_q       <= user_d;
            flush_pend_q <= flush_pend_d;
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign IN_READY      = in_ready_q;
    assign AXIS_M_TVALID = main_valid_q;
    assign AXIS_M_TDATA  = main_q.data;
    assign AXIS_M_TLAST  = main_q.last;
    assign AXIS_M_TID    = main_q.id;
    assign AXIS_M_TUSER  = main_q.user;
    assign AXIS_M_TDEST  = main_q.dest;
    assign PKT_CNT       = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_packetizer.sv
// ============================================================================
// Module   : tb_axis_packetizer
// Purpose  : Self-checking bench for axis_packetizer against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axis_packetizer;

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_DATA;
    logic [7:0]  CFG_LEN;
    logic [3:0]  CFG_DEST;
    logic [3:0]  CFG_ID;
    logic [3:0]  CFG_USER;
    logic        FLUSH;
    logic        AXIS_M_TVALID;
    logic        AXIS_M_TREADY;
    logic [31:0] AXIS_M_TDATA;
    logic        AXIS_M_TLAST;
    logic [3:0]  AXIS_M_TID;
    logic [3:0]  AXIS_M_TUSER;
    logic [3:0]  AXIS_M_TDEST;
    logic [15:0] PKT_CNT;

    axis_packetizer #(
        .DATAW(32), .IDW(4), .USERW(4), .DESTW(4), .LENW(8)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .CFG_LEN(CFG_LEN), .CFG_DEST(CFG_DEST), .CFG_ID(CFG_ID),
        .CFG_USER(CFG_USER), .FLUSH(FLUSH),
        .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
        .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST),
        .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TUSER(AXIS_M_TUSER),
        .AXIS_M_TDEST(AXIS_M_TDEST), .PKT_CNT(PKT_CNT)
    );

    typedef struct {
        logic [31:0] data;
        bit          last;
        logic [3:0]  id;
        logic [3:0]  user;
        logic [3:0]  dest;
    } beat_t;

    beat_t exp_q[$];
    beat_t out_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tr_mode  = 1;  // 0: TREADY low, 1: high, 2: random

    // model packet state: words still owed to the open packet
    bit          m_open;
    int          m_rem;
    bit          m_fpend;
    logic [3:0]  m_id, m_user, m_dest;
    int          m_pkts;
    bit          armed;
    bit          prev_stall;
    logic [62:0] prev_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        AXIS_M_TREADY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (tr_mode)
                0:       AXIS_M_TREADY = 1'b0;
                1:       AXIS_M_TREADY = 1'b1;
                default: AXIS_M_TREADY = 1'($urandom % 2);
            endcase
        end
    end

    // Monitor: at each falling edge compare outputs to the model, then apply
    // the handshakes that the coming rising edge will perform.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                chk("reset_outputs", {1'b0, AXIS_M_TVALID, IN_READY, AXIS_M_TLAST, AXIS_M_TDATA,
                                      AXIS_M_TID, AXIS_M_TUSER, AXIS_M_TDEST, PKT_CNT}, 64'd0);
                exp_q.delete();
                m_open = 0; m_rem = 0; m_fpend = 0; m_pkts = 0;
                armed = 0; prev_stall = 0;
            end else if (!armed) begin
                chk("first_cycle_ready", {62'd0, IN_READY, AXIS_M_TVALID}, 64'd0);
                armed = 1;
            end else begin
                chk("tvalid", 64'(AXIS_M_TVALID), 64'(exp_q.size() > 0));
                chk("in_ready", 64'(IN_READY), 64'(exp_q.size() < 2));
                chk("pkt_cnt", 64'(PKT_CNT), 64'(m_pkts[15:0]));
                if (AXIS_M_TVALID && exp_q.size() > 0) begin
                    chk("tdata", 64'(AXIS_M_TDATA), 64'(exp_q[0].data));
                    chk("tlast", 64'(AXIS_M_TLAST), 64'(exp_q[0].last));
                    chk("sideband", {52'd0, AXIS_M_TID, AXIS_M_TUSER, AXIS_M_TDEST},
                        {52'd0, exp_q[0].id, exp_q[0].user, exp_q[0].dest});
                end
                if (prev_stall)
                    chk("stable_stall", {1'b0, AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST,
                                         AXIS_M_TID, AXIS_M_TUSER, AXIS_M_TDEST, 16'd0},
                        {1'b0, prev_out});
                prev_stall = AXIS_M_TVALID && !AXIS_M_TREADY;
                prev_out   = {AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST,
                              AXIS_M_TID, AXIS_M_TUSER, AXIS_M_TDEST, 16'd0};
                if (AXIS_M_TVALID && AXIS_M_TREADY && exp_q.size() > 0) begin
                    beat_t o;
                    o.data = AXIS_M_TDATA; o.last = AXIS_M_TLAST;
                    o.id = AXIS_M_TID; o.user = AXIS_M_TUSER; o.dest = AXIS_M_TDEST;
                    out_log.push_back(o);
                    if (exp_q[0].last) m_pkts++;
                    void'(exp_q.pop_front());
                end
                if (IN_VALID && IN_READY) begin
                    beat_t b;
                    if (!m_open) begin
                        m_rem  = (CFG_LEN == 8'd0) ? 1 : int'(CFG_LEN);
                        m_id   = CFG_ID; m_user = CFG_USER; m_dest = CFG_DEST;
                        m_open = 1;
                    end
                    b.data = IN_DATA;
                    b.last = (m_rem == 1) || FLUSH || m_fpend;
                    b.id = m_id; b.user = m_user; b.dest = m_dest;
                    m_rem--;
                    m_fpend = 0;
                    if (b.last) m_open = 0;
                    exp_q.push_back(b);
                end else if (FLUSH) begin
                    m_fpend = 1;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit fl);
        bit got;
        int n;
        got = 0;
        n   = 0;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        FLUSH    = fl;
        while (!got && n < 1000) begin
            @(negedge CLK);
            got = IN_READY;
            @(posedge CLK);
            #1;
            n++;
        end
        IN_VALID = 1'b0;
        FLUSH    = 1'b0;
        if (!got) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #2;
            n++;
        end while (!(exp_q.size() == 0 && !AXIS_M_TVALID) && n < 2000);
        if (n >= 2000) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic set_cfg(input logic [7:0] l, input logic [3:0] d, input logic [3:0] i,
                           input logic [3:0] u);
        CFG_LEN = l; CFG_DEST = d; CFG_ID = i; CFG_USER = u;
    endtask

    initial begin
        int s, c0, t0;
        RST_N = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; FLUSH = 1'b0;
        set_cfg(8'd4, 4'd3, 4'd1, 4'd2);
        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Two back-to-back 4-beat packets at full rate
        s = out_log.size(); c0 = int'(PKT_CNT); t0 = cyc;
        for (int i = 0; i < 8; i++) send(32'h10 + 32'(i), 1'b0);
        chk("t1_rate_cycles", 64'(cyc - t0), 64'd8);
        drain();
        chk("t1_pkts", 64'(int'(PKT_CNT) - c0), 64'd2);
        chk("t1_last0", 64'(out_log[s+0].last), 64'd0);
        chk("t1_last2", 64'(out_log[s+2].last), 64'd0);
        chk("t1_last3", 64'(out_log[s+3].last), 64'd1);
        chk("t1_last7", 64'(out_log[s+7].last), 64'd1);
        chk("t1_data7", 64'(out_log[s+7].data), 64'h17);
        chk("t1_side5", {52'd0, out_log[s+5].dest, out_log[s+5].id, out_log[s+5].user}, 64'h312);

        // Zero length means single-beat packets
        set_cfg(8'd0, 4'd3, 4'd1, 4'd2);
        s = out_log.size(); c0 = int'(PKT_CNT);
        for (int i = 0; i < 3; i++) send(32'h20 + 32'(i), 1'b0);
        drain();
        chk("t2_pkts", 64'(int'(PKT_CNT) - c0), 64'd3);
        chk("t2_last1", 64'(out_log[s+1].last), 64'd1);

        // Flush on the second word of a 5-beat packet
        set_cfg(8'd5, 4'd3, 4'd1, 4'd2);
        s = out_log.size(); c0 = int'(PKT_CNT);
        send(32'h30, 1'b0);
        send(32'h31, 1'b1);
        for (int i = 0; i < 5; i++) send(32'h40 + 32'(i), 1'b0);
        drain();
        chk("t3_pkts", 64'(int'(PKT_CNT) - c0), 64'd2);
        chk("t3_flush_last", 64'(out_log[s+1].last), 64'd1);
        chk("t3_full_mid", 64'(out_log[s+5].last), 64'd0);
        chk("t3_full_last", 64'(out_log[s+6].last), 64'd1);

        // DEST change mid-packet applies only to the next packet
        set_cfg(8'd4, 4'd3, 4'd1, 4'd2);
        s = out_log.size();
        send(32'h50, 1'b0);
        send(32'h51, 1'b0);
        CFG_DEST = 4'd7;
        for (int i = 2; i < 8; i++) send(32'h50 + 32'(i), 1'b0);
        drain();
        chk("t5_dest_old", 64'(out_log[s+3].dest), 64'd3);
        chk("t5_dest_new", 64'(out_log[s+4].dest), 64'd7);

        // Random backpressure, random input gaps
        set_cfg(8'd4, 4'd5, 4'd6, 4'd9);
        tr_mode = 2;
        c0 = int'(PKT_CNT);
        for (int i = 0; i < 200; i++) begin
            if ($urandom % 4 == 0) begin
                @(posedge CLK); #1;
            end
            send($urandom, 1'b0);
        end
        tr_mode = 1;
        drain();
        chk("t4_pkts", 64'(int'(PKT_CNT) - c0), 64'd50);

        // Reset in the middle of a stalled packet
        tr_mode = 0;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        set_cfg(8'd4, 4'd3, 4'd1, 4'd2);
        send(32'h60, 1'b0);
        send(32'h61, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(AXIS_M_TVALID), 64'd0);
        chk("t6_rst_inready", 64'(IN_READY), 64'd0);
        chk("t6_rst_data", {31'd0, AXIS_M_TLAST, AXIS_M_TDATA}, 64'd0);
        chk("t6_rst_pktcnt", 64'(PKT_CNT), 64'd0);
        @(posedge CLK);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        tr_mode = 1;
        @(posedge CLK); #1;
        s = out_log.size();
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 1'b0);
        drain();
        chk("t6_beats", 64'(out_log.size() - s), 64'd4);
        chk("t6_first", 64'(out_log[s].data), 64'hA0);
        chk("t6_pktcnt", 64'(PKT_CNT), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
